// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window address generator.
// Holds the FSM encoding and the default widths used by the top level.
package conv_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } state_e;

    localparam int unsigned DimWDef  = 8;
    localparam int unsigned AddrWDef = 16;
    localparam int unsigned KMax     = 7;

endpackage

// File: rtl/conv_nested_counter.sv
// Single wrap counter; nxt_o exposes the next-state value so the parent
// can register outputs derived from the coming count.
module conv_nested_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] nxt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap_o = en_i & (cnt_q == limit_i);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nxt_o = cnt_d;

endmodule

// File: rtl/conv_window_addr_gen.sv
// Streams the K x K receptive-field read addresses for every output position
// of a convolution, flagging taps that land in the zero-padding border.
module conv_window_addr_gen
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDef,
    parameter int unsigned DIM_W  = DimWDef,
    parameter int unsigned K      = 3,
    parameter int unsigned TAP_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DIM_W-1:0]  i_size,
    input  logic [2:0]        i_pad,
    input  logic [2:0]        i_stride,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_pad,
    output logic [TAP_W-1:0]  o_tap,
    output logic              o_win_last,
    output logic              o_img_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned KW = $clog2(KMax + 1);
    // Output-grid counters need one extra bit: N + 2P - K can exceed 2^DIM_W - 1.
    localparam int unsigned CW = DIM_W + 1;

    state_e state_q, state_d;

    logic [DIM_W-1:0] n_q, n_c;
    logic [2:0]       p_q, p_c, s_q, s_c, s_in;
    logic [CW-1:0]    owl_q, owl_c;
    logic             cfg_bad, start_ok, advance;
    int               span, row_i, col_i;

    logic [KW-1:0] kx_n, ky_n;
    logic [CW-1:0] ox_n, oy_n;
    logic          kx_wrap, ky_wrap, ox_wrap, oy_wrap;

    logic [ADDR_W-1:0] addr_c, addr_q;
    logic [TAP_W-1:0]  tap_c, tap_q;
    logic              pad_c, pad_q, wl_c, wl_q, il_c, il_q;
    logic              valid_q, busy_q, done_q, err_q;

    // Config muxed so the first beat can be computed on the same edge it is latched.
    always_comb begin
        s_in     = (i_stride == 3'd0) ? 3'd1 : i_stride;
        span     = int'(i_size) + 2 * int'(i_pad) - int'(K);
        cfg_bad  = (span < 0) || (int'(i_pad) >= int'(K));
        start_ok = (state_q == StIdle) && i_start && !cfg_bad;
        n_c      = start_ok ? i_size : n_q;
        p_c      = start_ok ? i_pad : p_q;
        s_c      = start_ok ? s_in : s_q;
        owl_c    = start_ok ? CW'(span / int'(s_in)) : owl_q;
    end

    assign advance = valid_q & i_ready;

    conv_nested_counter #(.W(KW)) u_kx (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (start_ok),
        .en_i   (advance),
        .limit_i(KW'(K - 1)),
        .nxt_o  (kx_n),
        .wrap_o (kx_wrap)
    );

    conv_nested_counter #(.W(KW)) u_ky (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (start_ok),
        .en_i   (kx_wrap),
        .limit_i(KW'(K - 1)),
        .nxt_o  (ky_n),
        .wrap_o (ky_wrap)
    );

    conv_nested_counter #(.W(CW)) u_ox (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (start_ok),
        .en_i   (ky_wrap),
        .limit_i(owl_c),
        .nxt_o  (ox_n),
        .wrap_o (ox_wrap)
    );

    // oy wrapping coincides exactly with acceptance of the final beat.
    conv_nested_counter #(.W(CW)) u_oy (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (start_ok),
        .en_i   (ox_wrap),
        .limit_i(owl_c),
        .nxt_o  (oy_n),
        .wrap_o (oy_wrap)
    );

    always_comb begin
        row_i  = int'(oy_n) * int'(s_c) + int'(ky_n) - int'(p_c);
        col_i  = int'(ox_n) * int'(s_c) + int'(kx_n) - int'(p_c);
        pad_c  = (row_i < 0) || (row_i >= int'(n_c)) || (col_i < 0) || (col_i >= int'(n_c));
        addr_c = pad_c ? '0 : ADDR_W'(row_i * int'(n_c) + col_i);
        tap_c  = TAP_W'(int'(ky_n) * int'(K) + int'(kx_n));
        wl_c   = (ky_n == KW'(K - 1)) && (kx_n == KW'(K - 1));
        il_c   = wl_c && (ox_n == owl_c) && (oy_n == owl_c);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = cfg_bad ? StErr : StRun;
                end
            end
            StRun: begin
                if (oy_wrap) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            p_q     <= '0;
            s_q     <= '0;
            owl_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            pad_q   <= 1'b0;
            tap_q   <= '0;
            wl_q    <= 1'b0;
            il_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_c;
            p_q     <= p_c;
            s_q     <= s_c;
            owl_q   <= owl_c;
            busy_q  <= (state_d == StRun) || (state_d == StDone);
            done_q  <= (state_d == StDone);
            err_q   <= (state_d == StErr);
            if (start_ok || (advance && !oy_wrap)) begin
                valid_q <= 1'b1;
                addr_q  <= addr_c;
                pad_q   <= pad_c;
                tap_q   <= tap_c;
                wl_q    <= wl_c;
                il_q    <= il_c;
            end else if (oy_wrap) begin
                valid_q <= 1'b0;
                addr_q  <= '0;
                pad_q   <= 1'b0;
                tap_q   <= '0;
                wl_q    <= 1'b0;
                il_q    <= 1'b0;
            end
        end
    end

    assign o_addr     = addr_q;
    assign o_pad      = pad_q;
    assign o_tap      = tap_q;
    assign o_win_last = wl_q;
    assign o_img_last = il_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench for conv_window_addr_gen: a formula model queues expected
// beats per run, and a negedge monitor pops them as the DUT hands beats over.
module tb_conv_window_addr_gen;

    localparam int KK = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_ready = 1'b1;
    logic [7:0]  i_size = '0;
    logic [2:0]  i_pad = '0;
    logic [2:0]  i_stride = '0;
    logic [15:0] o_addr;
    logic        o_pad;
    logic [5:0]  o_tap;
    logic        o_win_last, o_img_last, o_valid, o_busy, o_done, o_err;

    conv_window_addr_gen #(
        .ADDR_W(16),
        .DIM_W (8),
        .K     (3),
        .TAP_W (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_size    (i_size),
        .i_pad     (i_pad),
        .i_stride  (i_stride),
        .o_addr    (o_addr),
        .o_pad     (o_pad),
        .o_tap     (o_tap),
        .o_win_last(o_win_last),
        .o_img_last(o_img_last),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int il_cyc = -1;
    int bp_left = 0;
    int hold_cnt = 0;
    bit bp_en = 1'b0;
    logic [24:0] sb[$];
    logic [24:0] beat_log[$];
    logic [24:0] ref_log[$];
    logic [24:0] mon_cur, mon_exp;
    int exp_w0[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] pack(input logic [15:0] a, input logic pd,
                                         input logic [5:0] t, input logic wl, input logic il);
        return {a, pd, t, wl, il};
    endfunction

    function automatic logic [31:0] log_addr(input int i);
        logic [24:0] b;
        b = beat_log[i];
        return 32'(b[24:9]);
    endfunction

    function automatic logic [31:0] log_pad(input int i);
        logic [24:0] b;
        b = beat_log[i];
        return 32'(b[8]);
    endfunction

    task automatic push_model(input int n, input int p, input int s);
        int se, ow, row, col, a;
        bit pd, wl, il;
        se = (s == 0) ? 1 : s;
        ow = (n + 2 * p - KK) / se + 1;
        for (int oy = 0; oy < ow; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < KK; ky++)
                    for (int kx = 0; kx < KK; kx++) begin
                        row = oy * se + ky - p;
                        col = ox * se + kx - p;
                        pd  = (row < 0) || (row >= n) || (col < 0) || (col >= n);
                        a   = pd ? 0 : row * n + col;
                        wl  = (ky == KK - 1) && (kx == KK - 1);
                        il  = wl && (ox == ow - 1) && (oy == ow - 1);
                        sb.push_back(pack(16'(a), pd, 6'(ky * KK + kx), wl, il));
                    end
    endtask

    // Ready is low only for bp_left cycles while the fifth beat is on offer.
    always @(posedge clk) begin
        #1;
        if (bp_en && acc_cnt == 4 && bp_left > 0) begin
            i_ready = 1'b0;
            bp_left--;
        end else begin
            i_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (!i_ready) begin
                if (bp_en) begin
                    check("bp_hold", 32'({o_addr, o_tap, o_win_last, o_img_last}),
                          32'({16'd5, 6'd4, 1'b0, 1'b0}));
                    hold_cnt++;
                end
            end else begin
                mon_cur = pack(o_addr, o_pad, o_tap, o_win_last, o_img_last);
                beat_log.push_back(mon_cur);
                acc_cnt++;
                if (o_img_last) il_cyc = cyc;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(mon_cur), 32'h0eadbeef);
                end else begin
                    mon_exp = sb.pop_front();
                    check("beat", 32'(mon_cur), 32'(mon_exp));
                end
            end
        end
    end

    task automatic run_cfg(input int n, input int p, input int s, input bit mid_start);
        bit seen;
        beat_log.delete();
        acc_cnt = 0;
        il_cyc = -1;
        push_model(n, p, s);
        i_size = 8'(n);
        i_pad = 3'(p);
        i_stride = 3'(s);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("first_valid", 32'(o_valid), 32'd1);
        check("busy_run", 32'(o_busy), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            if (mid_start && k == 5) begin
                i_start = 1'b1;
                i_size = 8'd7;
                i_pad = 3'd2;
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (o_done) seen = 1'b1;
        end
        i_start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("done_lat", 32'(cyc), 32'(il_cyc + 1));
            check("busy_done", 32'(o_busy), 32'd1);
            @(posedge clk);
            #1;
            check("done_pulse", 32'(o_done), 32'd0);
            check("idle", 32'(o_busy), 32'd0);
        end
        check("sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic err_cfg(input int n, input int p);
        i_size = 8'(n);
        i_pad = 3'(p);
        i_stride = 3'd1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("err_pulse", 32'(o_err), 32'd1);
        check("err_valid", 32'(o_valid), 32'd0);
        check("err_busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        #1;
        check("err_clear", 32'(o_err), 32'd0);
        check("err_no_valid", 32'(o_valid), 32'd0);
    endtask

    task automatic compare_ref(input string tag);
        int diffs;
        diffs = 0;
        check({tag, "_len"}, 32'(beat_log.size()), 32'(ref_log.size()));
        if (beat_log.size() == ref_log.size())
            for (int i = 0; i < beat_log.size(); i++)
                if (beat_log[i] !== ref_log[i]) diffs++;
        check({tag, "_diff"}, 32'(diffs), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wl_n, il_n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'({o_addr, o_pad, o_tap, o_win_last, o_img_last, o_valid, o_busy,
                              o_done, o_err}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_cfg(4, 0, 1, 1'b0);
        check("n4_cnt", 32'(beat_log.size()), 32'd36);
        if (beat_log.size() == 36) begin
            for (int i = 0; i < 9; i++) check("n4_w0_addr", log_addr(i), 32'(exp_w0[i]));
            check("n4_w1_addr", log_addr(9), 32'd1);
            wl_n = 0;
            il_n = 0;
            for (int i = 0; i < 36; i++) begin
                if (beat_log[i][1]) begin
                    wl_n++;
                    check("n4_wl_pos", 32'(i % 9), 32'd8);
                end
                if (beat_log[i][0]) il_n++;
            end
            check("n4_wl_cnt", 32'(wl_n), 32'd4);
            check("n4_il_cnt", 32'(il_n), 32'd1);
            check("n4_il_last", 32'(beat_log[35][0]), 32'd1);
        end
        ref_log = beat_log;

        run_cfg(4, 1, 1, 1'b0);
        check("p1_cnt", 32'(beat_log.size()), 32'd144);
        if (beat_log.size() == 144) begin
            for (int i = 0; i < 4; i++) begin
                check("p1_pad", log_pad(i), 32'd1);
                check("p1_pad_addr", log_addr(i), 32'd0);
            end
            check("p1_pad6", log_pad(6), 32'd1);
            check("p1_t4_pad", log_pad(4), 32'd0);
            check("p1_t4_addr", log_addr(4), 32'd0);
            check("p1_t8_addr", log_addr(8), 32'd5);
            check("p1_last_pad", log_pad(143), 32'd1);
        end

        run_cfg(5, 0, 2, 1'b0);
        check("s2_cnt", 32'(beat_log.size()), 32'd36);
        if (beat_log.size() == 36) begin
            check("s2_w1", log_addr(9), 32'd2);
            check("s2_w2", log_addr(18), 32'd10);
            check("s2_w3", log_addr(27), 32'd12);
        end

        run_cfg(5, 0, 1, 1'b0);
        ref_log = beat_log;
        run_cfg(5, 0, 0, 1'b0);
        compare_ref("s0_vs_s1");

        run_cfg(4, 0, 1, 1'b0);
        ref_log = beat_log;
        bp_en = 1'b1;
        bp_left = 3;
        hold_cnt = 0;
        run_cfg(4, 0, 1, 1'b0);
        bp_en = 1'b0;
        check("bp_cycles", 32'(hold_cnt), 32'd3);
        compare_ref("bp_seq");

        err_cfg(2, 0);
        err_cfg(8, 3);

        run_cfg(4, 0, 1, 1'b1);
        compare_ref("mid_start");

        beat_log.delete();
        acc_cnt = 0;
        push_model(4, 0, 1);
        i_size = 8'd4;
        i_pad = 3'd0;
        i_stride = 3'd1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        for (int k = 0; k < 200 && acc_cnt < 9; k++) begin
            @(posedge clk);
            #1;
        end
        check("rst_reach", 32'(acc_cnt), 32'd9);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_out", 32'({o_addr, o_pad, o_tap, o_win_last, o_img_last, o_valid, o_busy,
                                  o_done, o_err}), 32'd0);
        rst_n = 1'b1;
        sb.delete();
        check("rst_beats", 32'(beat_log.size()), 32'd9);
        @(posedge clk);
        #1;
        check("rst_no_done", 32'(o_done), 32'd0);
        run_cfg(4, 0, 1, 1'b0);
        compare_ref("replay");
        if (beat_log.size() > 0) check("replay_a0", log_addr(0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
